reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/cpu_pkg.sv | 10 +
 rtl/reg_file_if.sv | 24 ++
 rtl/register_en.sv | 17 +
 rtl/reg_file.sv | 63 ++++++
 tb/tb_reg_file.sv | 121 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants for the register file: register count, index width and the zero register.
package cpu_pkg;
   localparam int                   REG_COUNT = 32;
   localparam int                   REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] ZERO_REG  = 5'd31;

   function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
      return idx == ZERO_REG;
   endfunction
endpackage

// File: rtl/reg_file_if.sv
// Register file port bundle: one write port and two combinational read ports.
interface reg_file_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = 64
);
   logic                 RegWrite;
   logic [REG_IDX_W-1:0] WriteRegister;
   logic [WIDTH-1:0]     WriteData;
   logic [REG_IDX_W-1:0] ReadRegister1;
   logic [REG_IDX_W-1:0] ReadRegister2;
   logic [WIDTH-1:0]     ReadData1;
   logic [WIDTH-1:0]     ReadData2;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/register_en.sv
// WIDTH-bit storage register with load enable and asynchronous active-high clear.
module register_en #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/reg_file.sv
// 32 x WIDTH register file, X31 hard-wired to zero, two combinational read ports.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file
   import cpu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic     clk,
   input  logic     reset,
   reg_file_if.slave bus
);
   logic [REG_COUNT-2:0] we;
   logic [WIDTH-1:0]     q [REG_COUNT-1];
   logic [WIDTH-1:0]     rd1;
   logic [WIDTH-1:0]     rd2;

   // One-hot write decode; X31 has no storage so its enable line is never built.
   always_comb begin
      we = '0;
      for (int i = 0; i < REG_COUNT - 1; i++)
         we[i] = bus.RegWrite && !reset && (bus.WriteRegister == REG_IDX_W'(i));
   end

   for (genvar g = 0; g < REG_COUNT - 1; g++) begin : g_reg
      register_en #(.WIDTH(WIDTH)) u_reg (
         .clk   (clk),
         .reset (reset),
         .en    (we[g]),
         .d     (bus.WriteData),
         .q     (q[g])
      );
   end

   // 32:1 mux; index 31 (and an unknown index) falls through to zero.
   function automatic logic [WIDTH-1:0] read_sel(input logic [REG_IDX_W-1:0] idx);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < REG_COUNT - 1; i++)
         if (idx == REG_IDX_W'(i))
            r = q[i];
      return r;
   endfunction

   always_comb begin
      rd1 = read_sel(bus.ReadRegister1);
      rd2 = read_sel(bus.ReadRegister2);
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWrite && !is_zero_reg(bus.WriteRegister) &&
          (bus.WriteRegister == bus.ReadRegister1))
         rd1 = bus.WriteData;
      if (bus.RegWrite && !is_zero_reg(bus.WriteRegister) &&
          (bus.WriteRegister == bus.ReadRegister2))
         rd2 = bus.WriteData;
`endif
      if (reset) begin
         rd1 = '0;
         rd2 = '0;
      end
   end

   assign bus.ReadData1 = rd1;
   assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read data, a negedge monitor checks it.
module tb_reg_file;
   import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_file_if #(.WIDTH(64)) bus ();

   reg_file #(.WIDTH(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       nm;
      logic [63:0] e1;
      logic [63:0] e2;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (bus.ReadData1 !== e.e1 || bus.ReadData2 !== e.e2) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                     e.nm, bus.ReadData1, bus.ReadData2, e.e1, e.e2);
         end
      end
   end

   task automatic step(input logic rst_v, input logic wen, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst_v;
      bus.RegWrite      = wen;
      bus.WriteRegister = wr;
      bus.WriteData     = wd;
      bus.ReadRegister1 = r1;
      bus.ReadRegister2 = r2;
      e.nm = nm;
      e.e1 = e1;
      e.e2 = e2;
      sb.push_back(e);
   endtask

   localparam logic [63:0] V5  = 64'hCA35_0000_1234_5678;
   localparam logic [63:0] V0  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] V30 = 64'h8000_0000_0000_0001;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      reset             = 1'b1;
      bus.RegWrite      = 1'b0;
      bus.WriteRegister = '0;
      bus.WriteData     = '0;
      bus.ReadRegister1 = '0;
      bus.ReadRegister2 = '0;

      step(1, 0, 0, 0, 0, 1, 0, 0, "in_reset");
      step(1, 1, 2, ONES, 2, 2, 0, 0, "write_during_reset");
      for (int i = 0; i < 32; i++)
         step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, $sformatf("post_reset_idx%0d", i));

      step(0, 1, 5, V5, 0, 0, 0, 0, "write_x5");
      step(0, 0, 0, 0, 5, 4, V5, 0, "read_x5_x4");

      step(0, 1, 31, ONES, 31, 5, 0, V5, "write_x31");
      step(0, 0, 0, 0, 31, 31, 0, 0, "read_x31");

      step(0, 0, 7, 64'hE6F2, 7, 7, 0, 0, "no_write_x7");
      step(0, 0, 0, 0, 7, 5, 0, V5, "read_x7_after");

      step(0, 1, 9, 64'h1, 9, 9, BYP ? 64'h1 : 64'h0, BYP ? 64'h1 : 64'h0, "same_cycle_x9");
      step(0, 0, 0, 0, 9, 5, 64'h1, V5, "read_x9_after");

      step(0, 1, 0, V0, 5, 9, V5, 64'h1, "write_x0");
      step(0, 1, 30, V30, 0, 0, V0, V0, "write_x30");
      step(0, 0, 0, 0, 30, 0, V30, V0, "read_x30_x0");

      step(0, 1, 3, 64'hDEAD, 5, 30, V5, V30, "write_x3");
      step(0, 0, 0, 0, 3, 3, 64'hDEAD, 64'hDEAD, "read_x3");
      step(1, 1, 10, 64'h77, 3, 5, 0, 0, "mid_cycle_reset");
      step(0, 1, 12, 64'h55, 3, 10, 0, 0, "after_reset_x3_x10");
      step(0, 0, 0, 0, 12, 5, 64'h55, 0, "first_write_after_reset");
      step(0, 0, 0, 0, 0, 30, 0, 0, "reset_cleared_x0_x30");

      for (int k = 0; k < 10 && sb.size() > 0; k++)
         @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries unchecked, expected 0", sb.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
